uart_rx_ctrl: RTL

//  Frame sequencer for the UART receive path.
//  - Detects the start bit and times every bit with an edge counter.
//  - Drives one-cycle check enables into the start-glitch, data-deserializer,

---
 rtl/uart_rx_ctrl_if.sv | 43 ++++
 rtl/uart_rx_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Bundle of the signals exchanged between the UART receive frame sequencer
// and its surroundings (serial line, configuration, per-field checkers).
// The slave modport is the sequencer; the master modport is everything
// around it that feeds the line, the configuration and the checker results.
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_W = 6
);
  // Line and configuration into the sequencer
  logic                  i_rx_in;
  logic                  i_par_en;
  logic [PRESCALE_W-1:0] i_prescale;

  // Registered results coming back from the field checkers
  logic                  i_par_err;
  logic                  i_strt_glitch;
  logic                  i_stp_err;

  // Sequencer outputs
  logic                  o_dat_samp_en;
  logic [PRESCALE_W-1:0] o_edge_cnt;
  logic                  o_strt_chk_en;
  logic                  o_deser_en;
  logic                  o_par_chk_en;
  logic                  o_stp_chk_en;
  logic                  o_data_valid;
  logic                  o_frame_err;

  modport master (
    output i_rx_in, i_par_en, i_prescale,
    output i_par_err, i_strt_glitch, i_stp_err,
    input  o_dat_samp_en, o_edge_cnt,
    input  o_strt_chk_en, o_deser_en, o_par_chk_en, o_stp_chk_en,
    input  o_data_valid, o_frame_err
  );

  modport slave (
    input  i_rx_in, i_par_en, i_prescale,
    input  i_par_err, i_strt_glitch, i_stp_err,
    output o_dat_samp_en, o_edge_cnt,
    output o_strt_chk_en, o_deser_en, o_par_chk_en, o_stp_chk_en,
    output o_data_valid, o_frame_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer.
// Detects the start bit, times every bit with an edge counter, strobes the
// start/data/parity/stop checkers once per bit at the mid-bit strobe cycle,
// and reports each frame as a one-cycle data_valid or frame_err pulse.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_ctrl_if.slave   bus
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;

  // Checking states are encoded contiguously from 1 so the enable decode
  // below can index them directly.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [PRESCALE_W-1:0] r_p;
  logic                  r_par_en;
  logic                  r_err_lat;
  logic                  r_data_valid;
  logic                  r_frame_err;

  logic [PRESCALE_W-1:0] w_prescale_eff;
  logic                  w_last;
  logic                  w_strobe;
  logic [3:0]            w_chk_en;

  // Prescale below 8 is clamped so the strobe point always sits inside the bit.
  assign w_prescale_eff = (bus.i_prescale < PRESCALE_W'(8)) ? PRESCALE_W'(8)
                                                             : bus.i_prescale;

  // End-of-bit cycle E and mid-bit strobe cycle S, both against the latched P.
  assign w_last   = (r_edge_cnt == r_p - PRESCALE_W'(1));
  assign w_strobe = (r_edge_cnt == (r_p >> 1) + PRESCALE_W'(2));

  // One enable per checking state; only the current state's enable can fire,
  // so at most one is ever high.
  for (genvar gi = 0; gi < 4; gi++) begin : g_chk_en
    assign w_chk_en[gi] = (r_state == state_t'(3'(gi + 1))) && w_strobe;
  end

  assign bus.o_strt_chk_en = w_chk_en[0];
  assign bus.o_deser_en    = w_chk_en[1];
  assign bus.o_par_chk_en  = w_chk_en[2];
  assign bus.o_stp_chk_en  = w_chk_en[3];
  assign bus.o_dat_samp_en = (r_state != S_IDLE);
  assign bus.o_edge_cnt    = r_edge_cnt;
  assign bus.o_data_valid  = r_data_valid;
  assign bus.o_frame_err   = r_frame_err;

  // Frame sequencer: state, bit timing, config capture, error latch and
  // the registered end-of-frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_p          <= PRESCALE_W'(8);
      r_par_en     <= 1'b0;
      r_err_lat    <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-armed at STOP E below.
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;

      // Edge counter holds at 0 in IDLE (so the first START cycle reads 0)
      // and free-runs modulo P everywhere else.
      if (r_state == S_IDLE) begin
        r_edge_cnt <= '0;
      end else if (w_last) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (!bus.i_rx_in) begin
            r_state   <= S_START;
            r_p       <= w_prescale_eff;
            r_par_en  <= bus.i_par_en;
            r_err_lat <= 1'b0;
          end
        end

        S_START: begin
          if (w_last) begin
            if (bus.i_strt_glitch) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
        end

        S_DATA: begin
          if (w_last) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
            if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end
          end
        end

        S_PARITY: begin
          // A parity error is only remembered; the stop bit is still timed.
          if (w_last) begin
            r_err_lat <= r_err_lat | bus.i_par_err;
            r_state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_last) begin
            r_data_valid <= !(r_err_lat | bus.i_stp_err);
            r_frame_err  <=  (r_err_lat | bus.i_stp_err);
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
